// File: rtl/snake_step_engine.sv
// Snake body controller: owns the circular body store, steps the head, detects
// wall and self collisions, and streams erase / repaint / draw-head pixels.
module snake_step_engine #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int BLOCK    = 2,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 4,
    parameter int START_X  = 10,
    parameter int START_Y  = 10,
    parameter int WRAP     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic [1:0]                   dir,
    input  logic                         grow,
    input  logic [2:0]                   colour_in,
    output logic                         plot,
    output logic [X_W-1:0]               x_out,
    output logic [Y_W-1:0]               y_out,
    output logic [2:0]                   colour_out,
    output logic                         busy,
    output logic                         dead,
    output logic [$clog2(MAX_LEN+1)-1:0] length
);
    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int BB    = BLOCK * BLOCK;
    localparam int D_W   = (BB > 1) ? $clog2(BB) : 1;
    localparam int BS    = $clog2(BLOCK);
    localparam logic [D_W-1:0] D_LAST   = D_W'(BB - 1);
    localparam logic [D_W-1:0] COL_MASK = D_W'(BLOCK - 1);
    localparam logic [X_W-1:0] X_MAX    = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX    = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE    = Y_W'(1);
    localparam logic [2:0]     HEAD_C   = 3'b100;
    localparam logic [2:0]     ERASE_C  = 3'b000;

    typedef enum logic [3:0] {
        S_INIT_LOAD = 4'd0, S_INIT_DRAW = 4'd1, S_IDLE   = 4'd2,
        S_CALC      = 4'd3, S_CHECK     = 4'd4, S_ERASE  = 4'd5,
        S_REPAINT   = 4'd6, S_DRAW_HEAD = 4'd7, S_DEAD   = 4'd8
    } state_t;

    state_t           state_r;
    logic [LEN_W-1:0] k_r;
    logic [D_W-1:0]   d_r;
    logic [PTR_W-1:0] head_ptr_r;
    logic [1:0]       heading_r;
    logic             eff_grow_r;
    logic             hit_r;
    logic [X_W-1:0]   nh_x_r;
    logic [Y_W-1:0]   nh_y_r;
    logic [X_W-1:0]   store_x_r [MAX_LEN];
    logic [Y_W-1:0]   store_y_r [MAX_LEN];

    logic [X_W-1:0]   head_x_s, nx_s, cell_x_s, pix_x_s, wr_x_s;
    logic [Y_W-1:0]   head_y_s, ny_s, cell_y_s, pix_y_s, wr_y_s;
    logic             wall_s, match_s, reverse_s, wr_en_s;
    logic [LEN_W-1:0] len_m1_s;
    logic [PTR_W-1:0] rd_idx_s, tail_idx_s, wr_idx_s;
    logic [2:0]       pix_c_s;

    assign len_m1_s   = length - LEN_W'(1);
    assign rd_idx_s   = head_ptr_r - k_r[PTR_W-1:0];
    assign tail_idx_s = head_ptr_r - len_m1_s[PTR_W-1:0];
    assign reverse_s  = (dir[1] == heading_r[1]) && (dir[0] != heading_r[0]);
    // The tail only counts as an obstacle when it is not about to vacate.
    assign match_s    = (store_x_r[rd_idx_s] == nh_x_r) && (store_y_r[rd_idx_s] == nh_y_r)
                        && !((k_r == len_m1_s) && !eff_grow_r);

    // Next head cell and edge detection for the current heading.
    always_comb begin
        head_x_s = store_x_r[head_ptr_r];
        head_y_s = store_y_r[head_ptr_r];
        nx_s     = head_x_s;
        ny_s     = head_y_s;
        wall_s   = 1'b0;
        case (heading_r)
            2'd0: begin wall_s = (head_x_s == X_MAX);         nx_s = wall_s ? {X_W{1'b0}} : head_x_s + X_ONE; end
            2'd1: begin wall_s = (head_x_s == {X_W{1'b0}});   nx_s = wall_s ? X_MAX : head_x_s - X_ONE;       end
            2'd2: begin wall_s = (head_y_s == Y_MAX);         ny_s = wall_s ? {Y_W{1'b0}} : head_y_s + Y_ONE; end
            2'd3: begin wall_s = (head_y_s == {Y_W{1'b0}});   ny_s = wall_s ? Y_MAX : head_y_s - Y_ONE;       end
            default: wall_s = 1'b0;
        endcase
    end

    // Selects the cell and colour of the block currently being drawn.
    always_comb begin
        cell_x_s = {X_W{1'b0}};
        cell_y_s = {Y_W{1'b0}};
        pix_c_s  = ERASE_C;
        case (state_r)
            S_INIT_DRAW: begin
                cell_x_s = store_x_r[rd_idx_s];
                cell_y_s = store_y_r[rd_idx_s];
                pix_c_s  = (k_r == LEN_W'(0)) ? HEAD_C : colour_in;
            end
            S_ERASE:     begin cell_x_s = store_x_r[tail_idx_s]; cell_y_s = store_y_r[tail_idx_s]; pix_c_s = ERASE_C; end
            S_REPAINT:   begin cell_x_s = store_x_r[head_ptr_r]; cell_y_s = store_y_r[head_ptr_r]; pix_c_s = colour_in; end
            S_DRAW_HEAD: begin cell_x_s = nh_x_r; cell_y_s = nh_y_r; pix_c_s = HEAD_C; end
            default:     begin cell_x_s = {X_W{1'b0}}; cell_y_s = {Y_W{1'b0}}; pix_c_s = ERASE_C; end
        endcase
        pix_x_s = (cell_x_s << BS) + X_W'(d_r & COL_MASK);
        pix_y_s = (cell_y_s << BS) + Y_W'(d_r >> BS);
    end

    // Store write port: initial body load, then new head on DRAW_HEAD entry.
    always_comb begin
        wr_en_s  = 1'b0;
        wr_idx_s = {PTR_W{1'b0}};
        wr_x_s   = {X_W{1'b0}};
        wr_y_s   = {Y_W{1'b0}};
        if (state_r == S_INIT_LOAD) begin
            wr_en_s  = 1'b1;
            wr_idx_s = PTR_W'(INIT_LEN - 1) - k_r[PTR_W-1:0];
            wr_x_s   = X_W'(START_X) - X_W'(k_r);
            wr_y_s   = Y_W'(START_Y);
        end else if ((state_r == S_REPAINT) && (d_r == D_LAST)) begin
            wr_en_s  = 1'b1;
            wr_idx_s = head_ptr_r + PTR_W'(1);
            wr_x_s   = nh_x_r;
            wr_y_s   = nh_y_r;
        end else begin
            wr_en_s  = 1'b0;
        end
    end

    // Body coordinate store.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            store_x_r[wr_idx_s] <= wr_x_s;
            store_y_r[wr_idx_s] <= wr_y_s;
        end
    end

    // Step controller with registered pixel stream and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_INIT_LOAD;
            k_r        <= {LEN_W{1'b0}};
            d_r        <= {D_W{1'b0}};
            head_ptr_r <= {PTR_W{1'b0}};
            heading_r  <= 2'd0;
            eff_grow_r <= 1'b0;
            hit_r      <= 1'b0;
            nh_x_r     <= {X_W{1'b0}};
            nh_y_r     <= {Y_W{1'b0}};
            length     <= {LEN_W{1'b0}};
            plot       <= 1'b0;
            x_out      <= {X_W{1'b0}};
            y_out      <= {Y_W{1'b0}};
            colour_out <= 3'b000;
            busy       <= 1'b1;
            dead       <= 1'b0;
        end else begin
            plot <= 1'b0;
            case (state_r)
                S_INIT_LOAD: begin
                    if (k_r == LEN_W'(INIT_LEN - 1)) begin
                        k_r        <= {LEN_W{1'b0}};
                        d_r        <= {D_W{1'b0}};
                        head_ptr_r <= PTR_W'(INIT_LEN - 1);
                        length     <= LEN_W'(INIT_LEN);
                        heading_r  <= 2'd0;
                        state_r    <= S_INIT_DRAW;
                    end else begin
                        k_r <= k_r + LEN_W'(1);
                    end
                end
                S_INIT_DRAW, S_ERASE, S_REPAINT, S_DRAW_HEAD: begin
                    plot       <= 1'b1;
                    x_out      <= pix_x_s;
                    y_out      <= pix_y_s;
                    colour_out <= pix_c_s;
                    if (d_r == D_LAST) begin
                        d_r <= {D_W{1'b0}};
                        case (state_r)
                            S_INIT_DRAW: begin
                                if (k_r == LEN_W'(INIT_LEN - 1)) begin
                                    k_r     <= {LEN_W{1'b0}};
                                    busy    <= 1'b0;
                                    state_r <= S_IDLE;
                                end else begin
                                    k_r <= k_r + LEN_W'(1);
                                end
                            end
                            S_ERASE:   state_r <= S_REPAINT;
                            S_REPAINT: begin
                                head_ptr_r <= head_ptr_r + PTR_W'(1);
                                length     <= length + LEN_W'(eff_grow_r);
                                state_r    <= S_DRAW_HEAD;
                            end
                            S_DRAW_HEAD: begin
                                busy    <= 1'b0;
                                state_r <= S_IDLE;
                            end
                            default: state_r <= S_INIT_LOAD;
                        endcase
                    end else begin
                        d_r <= d_r + D_W'(1);
                    end
                end
                S_IDLE: begin
                    if (go) begin
                        heading_r  <= reverse_s ? heading_r : dir;
                        eff_grow_r <= grow && (length < LEN_W'(MAX_LEN));
                        busy       <= 1'b1;
                        state_r    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (wall_s && (WRAP == 32'sd0)) begin
                        dead    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= S_DEAD;
                    end else begin
                        nh_x_r  <= nx_s;
                        nh_y_r  <= ny_s;
                        k_r     <= {LEN_W{1'b0}};
                        hit_r   <= 1'b0;
                        state_r <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (k_r == len_m1_s) begin
                        k_r <= {LEN_W{1'b0}};
                        d_r <= {D_W{1'b0}};
                        if (hit_r || match_s) begin
                            dead    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= S_DEAD;
                        end else if (eff_grow_r) begin
                            state_r <= S_REPAINT;
                        end else begin
                            state_r <= S_ERASE;
                        end
                    end else begin
                        hit_r <= hit_r | match_s;
                        k_r   <= k_r + LEN_W'(1);
                    end
                end
                S_DEAD: begin
                    dead <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy    <= 1'b1;
                    state_r <= S_INIT_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snake_step_engine.sv
// Directed bench: dut_a uses defaults (wrapping), dut_b kills at walls with MAX_LEN = 8.
module tb_snake_step_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0, grow = 1'b0, sel = 1'b0;
    logic [1:0] dir = 2'd0;
    logic [2:0] colour_in = 3'b011;
    logic       go_a, go_b;
    logic       plot_a, plot_b, busy_a, busy_b, dead_a, dead_b;
    logic [7:0] x_a, x_b;
    logic [6:0] y_a, y_b;
    logic [2:0] c_a, c_b;
    logic [6:0] length_a;
    logic [3:0] length_b;
    logic       m_plot, m_busy, m_dead;
    logic [7:0] m_x;
    logic [6:0] m_y, m_len;
    logic [2:0] m_c;

    int vec = 0, miss = 0, lat = 0, n_plot = 0;
    logic [7:0] cap_x [64];
    logic [6:0] cap_y [64];
    logic [2:0] cap_c [64];

    always #5 clk = ~clk;

    assign go_a   = go & ~sel;
    assign go_b   = go & sel;
    assign m_plot = sel ? plot_b : plot_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_dead = sel ? dead_b : dead_a;
    assign m_x    = sel ? x_b : x_a;
    assign m_y    = sel ? y_b : y_a;
    assign m_c    = sel ? c_b : c_a;
    assign m_len  = sel ? {3'b000, length_b} : length_a;

    snake_step_engine dut_a (
        .clk(clk), .rst(rst), .go(go_a), .dir(dir), .grow(grow), .colour_in(colour_in),
        .plot(plot_a), .x_out(x_a), .y_out(y_a), .colour_out(c_a),
        .busy(busy_a), .dead(dead_a), .length(length_a)
    );

    snake_step_engine #(.WRAP(0), .MAX_LEN(8)) dut_b (
        .clk(clk), .rst(rst), .go(go_b), .dir(dir), .grow(grow), .colour_in(colour_in),
        .plot(plot_b), .x_out(x_b), .y_out(y_b), .colour_out(c_b),
        .busy(busy_b), .dead(dead_b), .length(length_b)
    );

    task automatic capture();
        if (m_plot) begin
            if (n_plot < 64) begin
                cap_x[n_plot] = m_x;
                cap_y[n_plot] = m_y;
                cap_c[n_plot] = m_c;
            end
            n_plot++;
        end
    endtask

    // One go pulse; lat = clock edges from the go edge until busy is seen low.
    task automatic do_step(input logic [1:0] d, input logic g);
        bit done;
        @(negedge clk); dir = d; grow = g; go = 1'b1;
        @(negedge clk); go = 1'b0;
        n_plot = 0; lat = 0; done = 1'b0;
        while (!done) begin
            capture();
            if (!m_busy || lat >= 300) done = 1'b1;
            else begin @(negedge clk); lat++; end
        end
    endtask

    task automatic hold_reset();
        @(negedge clk); rst = 1'b0; go = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_init();
        @(negedge clk); rst = 1'b1; lat = 0;
        while (busy_a && lat < 100) begin @(negedge clk); lat++; end
        vec++; if (lat !== 20) begin miss++; $display("FAIL init_wait: busy fell after %0d cycles, expected 20", lat); end
    endtask

    task automatic test_reset();
        hold_reset();
        vec++; if (plot_a !== 1'b0)      begin miss++; $display("FAIL reset_plot: got %b expected 0", plot_a); end
        vec++; if (x_a !== 8'd0 || y_a !== 7'd0) begin miss++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", x_a, y_a); end
        vec++; if (c_a !== 3'b000)       begin miss++; $display("FAIL reset_colour: got %b expected 000", c_a); end
        vec++; if (busy_a !== 1'b1)      begin miss++; $display("FAIL reset_busy: got %b expected 1", busy_a); end
        vec++; if (dead_a !== 1'b0)      begin miss++; $display("FAIL reset_dead: got %b expected 0", dead_a); end
        vec++; if (length_a !== 7'd0)    begin miss++; $display("FAIL reset_length: got %0d expected 0", length_a); end
        vec++; if (busy_b !== 1'b1 || length_b !== 4'd0) begin miss++; $display("FAIL reset_b: busy %b len %0d expected 1 0", busy_b, length_b); end
    endtask

    task automatic test_init();
        int ex, ey; bit done;
        logic [2:0] ec;
        sel = 1'b0;
        @(negedge clk); rst = 1'b1;
        n_plot = 0; lat = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk); lat++;
            capture();
            if (!m_busy || lat >= 200) done = 1'b1;
        end
        vec++; if (lat !== 20)    begin miss++; $display("FAIL init_latency: got %0d expected 20", lat); end
        vec++; if (n_plot !== 16) begin miss++; $display("FAIL init_plots: got %0d expected 16", n_plot); end
        for (int i = 0; i < 16; i++) begin
            ex = (10 - i / 4) * 2 + i % 2;
            ey = 20 + (i % 4) / 2;
            ec = (i < 4) ? 3'b100 : 3'b011;
            vec++;
            if (cap_x[i] !== 8'(ex) || cap_y[i] !== 7'(ey) || cap_c[i] !== ec) begin
                miss++; $display("FAIL init_pixel %0d: got (%0d,%0d,%b) expected (%0d,%0d,%b)", i, cap_x[i], cap_y[i], cap_c[i], ex, ey, ec);
            end
        end
        vec++; if (length_a !== 7'd4) begin miss++; $display("FAIL init_length: got %0d expected 4", length_a); end
    endtask

    task automatic test_straight();
        int ex, ey; int ecx [3]; logic [2:0] ecc [3];
        ecx = '{7, 10, 11}; ecc = '{3'b000, 3'b011, 3'b100};
        sel = 1'b0; do_step(2'd0, 1'b0);
        vec++; if (lat !== 17)    begin miss++; $display("FAIL straight_latency: got %0d expected 17", lat); end
        vec++; if (n_plot !== 12) begin miss++; $display("FAIL straight_plots: got %0d expected 12", n_plot); end
        for (int i = 0; i < 12; i++) begin
            ex = ecx[i / 4] * 2 + i % 2;
            ey = 20 + (i % 4) / 2;
            vec++;
            if (cap_x[i] !== 8'(ex) || cap_y[i] !== 7'(ey) || cap_c[i] !== ecc[i / 4]) begin
                miss++; $display("FAIL straight_pixel %0d: got (%0d,%0d,%b) expected (%0d,%0d,%b)", i, cap_x[i], cap_y[i], cap_c[i], ex, ey, ecc[i / 4]);
            end
        end
    endtask

    task automatic test_reverse();
        sel = 1'b0; do_step(2'd1, 1'b0);
        vec++; if (lat !== 17) begin miss++; $display("FAIL reverse_latency: got %0d expected 17", lat); end
        vec++; if (cap_x[8] !== 8'd24 || cap_y[8] !== 7'd20 || cap_c[8] !== 3'b100) begin
            miss++; $display("FAIL reverse_head: got (%0d,%0d,%b) expected (24,20,100)", cap_x[8], cap_y[8], cap_c[8]);
        end
    endtask

    task automatic test_tail_vacate();
        sel = 1'b0;
        do_step(2'd2, 1'b0);
        do_step(2'd1, 1'b0);
        do_step(2'd3, 1'b0);
        vec++; if (lat !== 17 || dead_a !== 1'b0) begin miss++; $display("FAIL vacate_survive: lat %0d dead %b expected 17 0", lat, dead_a); end
        vec++; if (cap_x[0] !== 8'd22 || cap_y[0] !== 7'd20 || cap_c[0] !== 3'b000) begin
            miss++; $display("FAIL vacate_erase: got (%0d,%0d,%b) expected (22,20,000)", cap_x[0], cap_y[0], cap_c[0]);
        end
        vec++; if (cap_x[11] !== 8'd23 || cap_y[11] !== 7'd21 || cap_c[11] !== 3'b100) begin
            miss++; $display("FAIL vacate_head: got (%0d,%0d,%b) expected (23,21,100)", cap_x[11], cap_y[11], cap_c[11]);
        end
    endtask

    task automatic test_grow();
        sel = 1'b0; do_step(2'd3, 1'b1);
        vec++; if (lat !== 13)    begin miss++; $display("FAIL grow_latency: got %0d expected 13", lat); end
        vec++; if (n_plot !== 8)  begin miss++; $display("FAIL grow_plots: got %0d expected 8", n_plot); end
        for (int i = 0; i < 8; i++) begin
            vec++; if (cap_c[i] === 3'b000) begin miss++; $display("FAIL grow_black %0d: got %b expected non-black", i, cap_c[i]); end
        end
        vec++; if (cap_x[4] !== 8'd22 || cap_y[4] !== 7'd18 || cap_c[4] !== 3'b100) begin
            miss++; $display("FAIL grow_head: got (%0d,%0d,%b) expected (22,18,100)", cap_x[4], cap_y[4], cap_c[4]);
        end
        vec++; if (length_a !== 7'd5) begin miss++; $display("FAIL grow_length: got %0d expected 5", length_a); end
    endtask

    task automatic test_body_collision();
        sel = 1'b0;
        do_step(2'd1, 1'b0);
        do_step(2'd2, 1'b0);
        do_step(2'd0, 1'b0);
        vec++; if (lat !== 6 || n_plot !== 0) begin miss++; $display("FAIL body_hit_timing: lat %0d plots %0d expected 6 0", lat, n_plot); end
        vec++; if (dead_a !== 1'b1 || length_a !== 7'd5) begin miss++; $display("FAIL body_hit_dead: dead %b len %0d expected 1 5", dead_a, length_a); end
    endtask

    task automatic test_grow_into_tail();
        hold_reset(); wait_init();
        sel = 1'b0;
        do_step(2'd2, 1'b0);
        do_step(2'd1, 1'b0);
        do_step(2'd3, 1'b1);
        vec++; if (lat !== 5 || n_plot !== 0 || dead_a !== 1'b1) begin
            miss++; $display("FAIL grow_tail_dead: lat %0d plots %0d dead %b expected 5 0 1", lat, n_plot, dead_a);
        end
    endtask

    task automatic test_wrap();
        int ecx [3]; logic [2:0] ecc [3]; int ex, ey;
        ecx = '{36, 39, 0}; ecc = '{3'b000, 3'b011, 3'b100};
        hold_reset(); wait_init();
        sel = 1'b0;
        for (int s = 0; s < 30; s++) do_step(2'd0, 1'b0);
        vec++; if (lat !== 17 || dead_a !== 1'b0) begin miss++; $display("FAIL wrap_step: lat %0d dead %b expected 17 0", lat, dead_a); end
        for (int i = 0; i < 12; i++) begin
            ex = ecx[i / 4] * 2 + i % 2;
            ey = 20 + (i % 4) / 2;
            vec++;
            if (cap_x[i] !== 8'(ex) || cap_y[i] !== 7'(ey) || cap_c[i] !== ecc[i / 4]) begin
                miss++; $display("FAIL wrap_pixel %0d: got (%0d,%0d,%b) expected (%0d,%0d,%b)", i, cap_x[i], cap_y[i], cap_c[i], ex, ey, ecc[i / 4]);
            end
        end
    endtask

    task automatic test_max_len_and_wall();
        sel = 1'b1;
        for (int s = 0; s < 4; s++) begin
            do_step(2'd0, 1'b1);
            vec++; if (lat !== 13 + s) begin miss++; $display("FAIL b_grow_latency %0d: got %0d expected %0d", s, lat, 13 + s); end
        end
        vec++; if (m_len !== 7'd8) begin miss++; $display("FAIL b_length_full: got %0d expected 8", m_len); end
        do_step(2'd0, 1'b1);
        vec++; if (lat !== 21 || n_plot !== 12) begin miss++; $display("FAIL b_full_grow: lat %0d plots %0d expected 21 12", lat, n_plot); end
        vec++; if (cap_x[0] !== 8'd14 || cap_y[0] !== 7'd20 || cap_c[0] !== 3'b000) begin
            miss++; $display("FAIL b_full_erase: got (%0d,%0d,%b) expected (14,20,000)", cap_x[0], cap_y[0], cap_c[0]);
        end
        vec++; if (m_len !== 7'd8) begin miss++; $display("FAIL b_length_capped: got %0d expected 8", m_len); end
        for (int s = 0; s < 24; s++) do_step(2'd0, 1'b0);
        vec++; if (m_dead !== 1'b0 || lat !== 21) begin miss++; $display("FAIL b_at_edge: dead %b lat %0d expected 0 21", m_dead, lat); end
        do_step(2'd0, 1'b0);
        vec++; if (lat !== 1 || n_plot !== 0 || m_dead !== 1'b1) begin
            miss++; $display("FAIL b_wall: lat %0d plots %0d dead %b expected 1 0 1", lat, n_plot, m_dead);
        end
        do_step(2'd2, 1'b0);
        vec++; if (lat !== 0 || n_plot !== 0 || m_dead !== 1'b1 || m_busy !== 1'b0) begin
            miss++; $display("FAIL b_dead_go: lat %0d plots %0d dead %b busy %b expected 0 0 1 0", lat, n_plot, m_dead, m_busy);
        end
    endtask

    task automatic test_reset_abort();
        sel = 1'b0;
        @(negedge clk); dir = 2'd0; grow = 1'b0; go = 1'b1;
        @(negedge clk); go = 1'b0;
        repeat (8) @(negedge clk);
        vec++; if (plot_a !== 1'b1) begin miss++; $display("FAIL abort_midstep: plot %b expected 1", plot_a); end
        #2 rst = 1'b0;
        #1;
        vec++; if (plot_a !== 1'b0 || busy_a !== 1'b1 || length_a !== 7'd0) begin
            miss++; $display("FAIL abort_async: plot %b busy %b len %0d expected 0 1 0", plot_a, busy_a, length_a);
        end
        repeat (2) @(negedge clk);
        wait_init();
        vec++; if (length_a !== 7'd4 || dead_a !== 1'b0) begin miss++; $display("FAIL abort_reinit: len %0d dead %b expected 4 0", length_a, dead_a); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_straight();
        test_reverse();
        test_tail_vacate();
        test_grow();
        test_body_collision();
        test_grow_into_tail();
        test_wrap();
        test_max_len_and_wall();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
